stream_demux: RTL

- Registered 1-to-N stream demultiplexer with a valid/ready handshake.
- Routes each input beat to one of NUM_CH output channels, chosen by a select that travels with the beat.
- Each channel has its own holding register, so a stalled channel blocks only beats addressed to it.
- Out-of-range selects are dropped and counted.
- Generalises the team's combinational 2-way demux for datapath fan-out between stream stages.

---
 rtl/stream_demux.sv | 78 +++++++
 1 files changed

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: each beat is steered by its select into a
// per-channel holding register; out-of-range selects are dropped and counted.
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_count
);

    // One extra bit so NUM_CH == 2**SEL_W is representable in the compare.
    localparam logic [SEL_W:0] LP_NUM_CH = (SEL_W + 1)'(NUM_CH);

    logic                     w_legal;
    logic                     w_xfer;
    logic                     w_drop;
    logic [NUM_CH-1:0]        w_hit;
    logic [NUM_CH-1:0]        w_load;

    logic [NUM_CH*DATA_W-1:0] r_data;
    logic [NUM_CH-1:0]        r_valid;
    logic                     r_drop_pulse;
    logic [CNT_W-1:0]         r_drop_count;

    assign w_legal = ({1'b0, in_sel} < LP_NUM_CH);

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit[k] = ({1'b0, in_sel} == (SEL_W + 1)'(k));
        end
    end

    // Only the addressed channel gates acceptance; illegal beats are always taken.
    assign in_ready = w_legal ? |(w_hit & (~r_valid | out_ready)) : 1'b1;
    assign w_xfer   = in_valid & in_ready;
    assign w_load   = w_hit & {NUM_CH{w_xfer}};
    assign w_drop   = w_xfer & ~w_legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data       <= '0;
            r_valid      <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_load[k]) begin
                    r_data[k*DATA_W +: DATA_W] <= in_data;
                    r_valid[k]                 <= 1'b1;
                end else if (r_valid[k] && out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign drop_pulse = r_drop_pulse;
    assign drop_count = r_drop_count;

endmodule
